ucie_ctl_sb_rx_depacketizer: RTL and testbench

Sideband receive path of the CTL adapter. It is the link-partner consumer of the packets produced by the sideband TX top. It deserializes NC-bit RDI config beats (pl_cfg) into 32-bit phases, assembles header and optional data, and decodes opcode/msgcode/subcode into the 5-bit CTL message decode plus the advertised-capability value. It returns RDI config credits to the transmitter via lp_cfg_crd.

---
 rtl/ucie_ctl_sb_rx_depacketizer.sv | 239 +++++++++++++++++++++++
 tb/tb_ucie_ctl_sb_rx_depacketizer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_rx_depacketizer.sv
// Sideband RX depacketizer: deserializes RDI config beats into phases, decodes CTL messages, returns credits.
// Optional SB_RX_PARITY_CHK_EN enables CP/DP parity checking of received packets.
module ucie_ctl_sb_rx_depacketizer #(
    parameter int unsigned NC = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rdi_pl_cfg_vld,
    input  logic [NC-1:0] i_rdi_pl_cfg,
    output logic          o_rdi_lp_cfg_crd,
    output logic          o_valid_pl_sb,
    input  logic          i_ready_pl_sb,
    output logic [4:0]    o_pl_sb_decode,
    output logic [31:0]   o_pl_adv_cap_value,
    output logic          o_pl_sb_err
);
    localparam int unsigned BEATS = 32 / NC;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [4:0]    OPC_NODATA = 5'b10010;
    localparam logic [4:0]    OPC_DATA   = 5'b11011;
    localparam logic [4:0]    DEC_ADVCAP = 5'b01000;

    typedef enum logic [2:0] {
        S_CRD_INIT, S_P0, S_P1, S_D0, S_D1, S_DEC, S_DLV, S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [1:0]    phase_q, phase_d;
    logic [31:0]   cur_q, cur_d;
    logic [4:0]    opc_q, opc_d;
    logic [7:0]    msg_q, msg_d;
    logic [7:0]    sub_q, sub_d;
    logic [31:0]   adv_q, adv_d;
    logic          crd_q, crd_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic [4:0]    dec_q, dec_d;
    logic [31:0]   val_q, val_d;
    logic [31:0]   phase_w;
    logic          collect, beat_in, wrap;
    logic          known_c, par_ok_c;
    logic [4:0]    map_c;

    assign collect = (state_q == S_P0) || (state_q == S_P1) || (state_q == S_D0) || (state_q == S_D1);
    assign beat_in = collect && i_rdi_pl_cfg_vld;
    assign wrap    = beat_in && (beat_q == LAST_BEAT);

    // Current phase with the incoming beat merged into its slot
    always_comb begin
        phase_w = cur_q;
        phase_w[32'(beat_q) * NC +: NC] = i_rdi_pl_cfg;
    end

    // Message map from msgcode/subcode/opcode
    always_comb begin
        known_c = 1'b0;
        map_c   = 5'd0;
        if ((msg_q == 8'h01 || msg_q == 8'h02) && opc_q == OPC_NODATA) begin
            known_c  = 1'b1;
            map_c[4] = (msg_q == 8'h02);
            case (sub_q)
                8'h01:   map_c[3:0] = 4'd1;
                8'h04:   map_c[3:0] = 4'd2;
                8'h08:   map_c[3:0] = 4'd3;
                8'h09:   map_c[3:0] = 4'd4;
                8'h0A:   map_c[3:0] = 4'd5;
                8'h0B:   map_c[3:0] = 4'd6;
                8'h0C:   map_c[3:0] = 4'd7;
                default: known_c    = 1'b0;
            endcase
        end else if (msg_q == 8'h03 && opc_q == OPC_DATA && sub_q == 8'h00) begin
            known_c = 1'b1;
            map_c   = DEC_ADVCAP;
        end
    end

`ifdef SB_RX_PARITY_CHK_EN
    logic cp_q, cp_d, dp_q, dp_d, cpx_q, cpx_d, dpx_q, dpx_d;

    // Running parity of received phases; DP reference stays 0 for no-data packets
    always_comb begin
        cp_d  = cp_q;
        dp_d  = dp_q;
        cpx_d = cpx_q;
        dpx_d = dpx_q;
        if (wrap) begin
            case (phase_q)
                2'd0: cpx_d = ^phase_w;
                2'd1: begin
                    cpx_d = cpx_q ^ (^phase_w[29:0]);
                    cp_d  = phase_w[31];
                    dp_d  = phase_w[30];
                    dpx_d = 1'b0;
                end
                2'd2:    dpx_d = ^phase_w;
                default: dpx_d = dpx_q ^ (^phase_w);
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cp_q  <= 1'b0;
            dp_q  <= 1'b0;
            cpx_q <= 1'b0;
            dpx_q <= 1'b0;
        end else begin
            cp_q  <= cp_d;
            dp_q  <= dp_d;
            cpx_q <= cpx_d;
            dpx_q <= dpx_d;
        end
    end

    assign par_ok_c = (cp_q == cpx_q) && (dp_q == dpx_q);
`else
    assign par_ok_c = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        phase_d = phase_q;
        cur_d   = cur_q;
        opc_d   = opc_q;
        msg_d   = msg_q;
        sub_d   = sub_q;
        adv_d   = adv_q;
        crd_d   = 1'b0;
        err_d   = 1'b0;
        vld_d   = vld_q;
        dec_d   = dec_q;
        val_d   = val_q;

        if (beat_in) begin
            cur_d  = phase_w;
            beat_d = wrap ? '0 : beat_q + 1'b1;
        end
        if (wrap) begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
                2'd0: begin
                    opc_d = phase_w[4:0];
                    msg_d = phase_w[21:14];
                end
                2'd1:    sub_d = phase_w[15:8];
                2'd2:    adv_d = phase_w;
                default: ;
            endcase
        end

        case (state_q)
            S_CRD_INIT: begin
                crd_d   = 1'b1;
                state_d = S_P0;
            end
            S_P0: if (wrap) state_d = S_P1;
            S_P1: if (wrap) begin
                if (opc_q == OPC_DATA)        state_d = S_D0;
                else if (opc_q == OPC_NODATA) state_d = S_DEC;
                else                          state_d = S_DROP;
            end
            S_D0: if (wrap) state_d = S_D1;
            S_D1: if (wrap) state_d = S_DEC;
            S_DEC: begin
                if (known_c && par_ok_c) begin
                    state_d = S_DLV;
                    vld_d   = 1'b1;
                    dec_d   = map_c;
                    val_d   = (map_c == DEC_ADVCAP) ? adv_q : 32'd0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DLV: if (i_ready_pl_sb) begin
                vld_d   = 1'b0;
                dec_d   = 5'd0;
                val_d   = 32'd0;
                crd_d   = 1'b1;
                state_d = S_P0;
            end
            S_DROP: begin
                crd_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_P0;
            end
            default: state_d = S_CRD_INIT;
        endcase

        // Packet complete: rewind phase count for the next packet
        if (collect && (state_d == S_DEC || state_d == S_DROP)) phase_d = 2'd0;

        // Beat with no credit outstanding is discarded and flagged
        if (i_rdi_pl_cfg_vld && (state_q == S_DEC || state_q == S_DLV || state_q == S_DROP))
            err_d = 1'b1;
        err_d = err_d & ~err_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_CRD_INIT;
            beat_q  <= '0;
            phase_q <= 2'd0;
            cur_q   <= 32'd0;
            opc_q   <= 5'd0;
            msg_q   <= 8'd0;
            sub_q   <= 8'd0;
            adv_q   <= 32'd0;
            crd_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            dec_q   <= 5'd0;
            val_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            phase_q <= phase_d;
            cur_q   <= cur_d;
            opc_q   <= opc_d;
            msg_q   <= msg_d;
            sub_q   <= sub_d;
            adv_q   <= adv_d;
            crd_q   <= crd_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            dec_q   <= dec_d;
            val_q   <= val_d;
        end
    end

    assign o_rdi_lp_cfg_crd   = crd_q;
    assign o_pl_sb_err        = err_q;
    assign o_valid_pl_sb      = vld_q;
    assign o_pl_sb_decode     = dec_q;
    assign o_pl_adv_cap_value = val_q;

endmodule

// File: tb/tb_ucie_ctl_sb_rx_depacketizer.sv
// Self-checking bench for ucie_ctl_sb_rx_depacketizer: vector table, corner sequences, randomized packets vs model.
module tb_ucie_ctl_sb_rx_depacketizer;
    localparam int NC = 16;
    localparam logic [4:0] OPC_NODATA = 5'b10010;
    localparam logic [4:0] OPC_DATA   = 5'b11011;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [NC-1:0] cfg;
    logic          crd;
    logic          valid;
    logic          rdy;
    logic [4:0]    dec;
    logic [31:0]   value;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucie_ctl_sb_rx_depacketizer #(.NC(NC)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rdi_pl_cfg_vld   (vld),
        .i_rdi_pl_cfg       (cfg),
        .o_rdi_lp_cfg_crd   (crd),
        .o_valid_pl_sb      (valid),
        .i_ready_pl_sb      (rdy),
        .o_pl_sb_decode     (dec),
        .o_pl_adv_cap_value (value),
        .o_pl_sb_err        (err)
    );

    typedef struct {
        logic [3:0][31:0] ph;
        int               nph;
        int               gap;
        int               rdy_wait;
        bit               exp_known;
        logic [4:0]       exp_dec;
        logic [31:0]      exp_val;
        int               exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                 input logic [31:0] p3, input int nph, input int gap, input int rw,
                                 input bit k, input logic [4:0] d, input logic [31:0] v, input int lat);
        vec_t t;
        t.ph = {p3, p2, p1, p0};
        t.nph = nph; t.gap = gap; t.rdy_wait = rw;
        t.exp_known = k; t.exp_dec = d; t.exp_val = v; t.exp_lat = lat;
        return t;
    endfunction

    // Reference behaviour derived from the packet rules
    function automatic void model(input logic [3:0][31:0] ph, output bit known, output logic [4:0] d,
                                  output logic [31:0] v, output int lat, output int nph);
        logic [4:0] opc;
        logic [7:0] msg, sub;
        logic [7:0] sub_tab [7];
        sub_tab = '{8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        opc = ph[0][4:0];
        msg = ph[0][21:14];
        sub = ph[1][15:8];
        known = 0; d = 5'd0; v = 32'd0;
        if (opc != OPC_NODATA && opc != OPC_DATA) begin
            lat = 2; nph = 2;
            return;
        end
        nph = (opc == OPC_DATA) ? 4 : 2;
        if ((msg == 8'h01 || msg == 8'h02) && opc == OPC_NODATA) begin
            for (int i = 0; i < 7; i++)
                if (sub == sub_tab[i]) begin
                    known = 1;
                    d = {msg == 8'h02, 4'(i + 1)};
                end
        end else if (msg == 8'h03 && opc == OPC_DATA && sub == 8'h00) begin
            known = 1; d = 5'b01000; v = ph[2];
        end
`ifdef SB_RX_PARITY_CHK_EN
        if (ph[1][31] != (^ph[0] ^ ^ph[1][29:0])) known = 0;
        if (ph[1][30] != ((nph == 4) ? (^ph[2] ^ ^ph[3]) : 1'b0)) known = 0;
`endif
        if (!known) begin d = 5'd0; v = 32'd0; end
        lat = known ? 2 : 3;
    endfunction

    task automatic send_phase(input logic [31:0] ph, input int gap);
        for (int k = 0; k < 32 / NC; k++) begin
            repeat (gap) begin @(posedge clk); #1; end
            vld = 1'b1;
            cfg = ph[k*NC +: NC];
            @(posedge clk); #1;
            vld = 1'b0;
        end
    endtask

    task automatic run_pkt(input string tag, input vec_t t);
        int cyc;
        bit seen;
        rdy = (t.rdy_wait == 0);
        for (int p = 0; p < t.nph; p++) send_phase(t.ph[p], t.gap);
        cyc = 0; seen = 0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (valid || err) seen = 1;
        end
        chk($sformatf("%s.response", tag), 32'(seen), 32'd1);
        if (!seen) return;
        chk($sformatf("%s.latency", tag), cyc, t.exp_lat);
        chk($sformatf("%s.valid", tag), 32'(valid), 32'(t.exp_known));
        if (t.exp_known) begin
            chk($sformatf("%s.decode", tag), 32'(dec), 32'(t.exp_dec));
            chk($sformatf("%s.value", tag), value, t.exp_val);
            chk($sformatf("%s.crd_err_idle", tag), {30'd0, crd, err}, 32'd0);
            for (int i = 0; i < t.rdy_wait; i++) begin
                @(negedge clk);
                chk($sformatf("%s.hold", tag), {25'd0, valid, crd, dec}, {25'd0, 1'b1, 1'b0, t.exp_dec});
                chk($sformatf("%s.hold_value", tag), value, t.exp_val);
            end
            if (t.rdy_wait > 0) begin
                @(posedge clk); #1; rdy = 1'b1;
                @(negedge clk);
            end
            @(posedge clk); #1; rdy = 1'b0;
            @(negedge clk);
            chk($sformatf("%s.accept_crd", tag), {30'd0, crd, valid}, 32'd2);
            @(negedge clk);
            chk($sformatf("%s.crd_width", tag), 32'(crd), 32'd0);
        end else begin
            chk($sformatf("%s.drop_pulses", tag), {30'd0, err, crd}, 32'd3);
            @(negedge clk);
            chk($sformatf("%s.drop_width", tag), {30'd0, err, crd}, 32'd0);
        end
    endtask

    task automatic do_reset();
        int n;
        rst = 1'b1; vld = 1'b0; rdy = 1'b0; cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", {24'd0, crd, valid, err, dec}, 32'd0);
        chk("reset.value", value, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (crd) n++;
            chk("init.quiet", {29'd0, valid, err, |dec}, 32'd0);
        end
        chk("init.credit_count", n, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t t;
        int   cyc;

        vecs.push_back(mkv(32'h00004012, 32'h00000400, 0, 0, 2, 1, 0, 1, 5'b00010, 0, 2));
        vecs.push_back(mkv(32'h0000C01B, 32'h00000000, 32'hA5A50F0F, 32'hFFFFFFFF, 4, 0, 5, 1, 5'b01000, 32'hA5A50F0F, 2));
        vecs.push_back(mkv(32'h001FC012, 32'h00000400, 0, 0, 2, 0, 0, 0, 5'd0, 0, 3));
        vecs.push_back(mkv(32'h00008012, 32'h00000B00, 0, 0, 2, 0, 2, 1, 5'b10110, 0, 2));
        vecs.push_back(mkv(32'h0000401B, 32'h00000400, 32'h12345678, 0, 4, 0, 0, 0, 5'd0, 0, 3));
        vecs.push_back(mkv(32'h00004000, 32'h00000400, 0, 0, 2, 1, 0, 0, 5'd0, 0, 2));
        vecs.push_back(mkv(32'h00004012, 32'h80000C00, 0, 0, 2, 0, 1, 1, 5'b00111, 0, 2));
        vecs.push_back(mkv(32'h0000C01B, 32'h00000100, 32'h0BADF00D, 0, 4, 0, 0, 0, 5'd0, 0, 3));
`ifdef SB_RX_PARITY_CHK_EN
        vecs.push_back(mkv(32'h00004012, 32'h80000400, 0, 0, 2, 0, 0, 0, 5'd0, 0, 3));
`endif

        do_reset();

        foreach (vecs[i]) run_pkt($sformatf("vec%0d", i), vecs[i]);

        // Extra beat while a message is held: flagged, message untouched
        rdy = 1'b0;
        send_phase(32'h00004012, 0);
        send_phase(32'h00000400, 0);
        cyc = 0;
        while (!valid && cyc < 8) begin @(negedge clk); cyc++; end
        chk("ovf.valid", 32'(valid), 32'd1);
        @(posedge clk); #1; vld = 1'b1; cfg = '1;
        @(posedge clk); #1; vld = 1'b0;
        @(negedge clk);
        chk("ovf.err", {29'd0, err, valid, crd}, 32'b110);
        chk("ovf.held_decode", 32'(dec), 32'(5'b00010));
        @(negedge clk);
        chk("ovf.err_width", 32'(err), 32'd0);
        @(posedge clk); #1; rdy = 1'b1;
        @(posedge clk); #1; rdy = 1'b0;
        @(negedge clk);
        chk("ovf.accept_crd", {30'd0, crd, valid}, 32'd2);
        run_pkt("ovf.next", vecs[3]);

        // Reset in the middle of a packet discards the partial phase
        send_phase(32'h00004012, 0);
        do_reset();
        run_pkt("midrst.next", vecs[0]);

        // Randomized packets against the model
        for (int r = 0; r < 60; r++) begin
            logic [7:0] sub;
            t.ph[0] = $urandom;
            t.ph[1] = $urandom;
            t.ph[2] = $urandom;
            t.ph[3] = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    t.ph[0][4:0] = OPC_NODATA;
                2, 3:    t.ph[0][4:0] = OPC_DATA;
                default: t.ph[0][4:0] = 5'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       t.ph[0][21:14] = 8'h01;
                1:       t.ph[0][21:14] = 8'h02;
                2:       t.ph[0][21:14] = 8'h03;
                3:       t.ph[0][21:14] = 8'($urandom);
                default: t.ph[0][21:14] = 8'h01;
            endcase
            case ($urandom_range(0, 8))
                0: sub = 8'h00;  1: sub = 8'h01;  2: sub = 8'h04;
                3: sub = 8'h08;  4: sub = 8'h09;  5: sub = 8'h0A;
                6: sub = 8'h0B;  7: sub = 8'h0C;
                default: sub = 8'($urandom);
            endcase
            t.ph[1][15:8] = sub;
            t.ph[1][31] = ^t.ph[0] ^ ^t.ph[1][29:0];
            t.ph[1][30] = (t.ph[0][4:0] == OPC_DATA) ? (^t.ph[2] ^ ^t.ph[3]) : 1'b0;
            if ($urandom_range(0, 7) == 0) t.ph[1][31] = ~t.ph[1][31];
            model(t.ph, t.exp_known, t.exp_dec, t.exp_val, t.exp_lat, t.nph);
            t.gap = $urandom_range(0, 2);
            t.rdy_wait = $urandom_range(0, 3);
            run_pkt($sformatf("rnd%0d", r), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
